// File: rtl/dm_pkg.sv
// Shared types and constants for the dot-matrix scan arbiter.
// Holds the arbiter state enum, blank row/column codes and the row decoder.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } dm_state_e;

    localparam logic [7:0] ROW_ALL_OFF = 8'hFF;
    localparam logic [7:0] COL_OFF     = 8'h00;

    // Active-low one-hot select for the given row.
    function automatic logic [7:0] row_onehot_n(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/dm_row_scanner.sv
// Row sequencer: row index counter, row select (cow) and frame_done pulse.
// Ports: clk, rst, tick (row step), clear (force blank/row 0), hold (blank
// step, row stays 0); outputs row_idx, cow (active low), frame_done.
module dm_row_scanner
    import dm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clear,
    input  logic       hold,
    output logic [2:0] row_idx,
    output logic [7:0] cow,
    output logic       frame_done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row_idx    <= 3'd0;
            cow        <= ROW_ALL_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                if (hold) begin
                    cow     <= ROW_ALL_OFF;
                    row_idx <= 3'd0;
                end else begin
                    cow        <= row_onehot_n(row_idx);
                    row_idx    <= row_idx + 3'd1;
                    frame_done <= (row_idx == 3'd7);
                end
            end
        end
    end

endmodule

// File: rtl/dm_scan_arbiter.sv
// Shares the 8x8 red/green matrix between two sources, switching owner only
// at frame boundaries with a minimum dwell and a blanking gap.
// Ports: clk, rst, scan_tick, en, req[1:0], src0/src1 red/green row data in;
// grant, row_idx, color_red, color_green, cow, frame_done out.
module dm_scan_arbiter
    import dm_pkg::*;
#(
    parameter int DWELL_FRAMES = 64,
    parameter int BLANK_STEPS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic [2:0] row_idx,
    input  logic [7:0] src0_red,
    input  logic [7:0] src0_green,
    input  logic [7:0] src1_red,
    input  logic [7:0] src1_green,
    output logic [7:0] color_red,
    output logic [7:0] color_green,
    output logic [7:0] cow,
    output logic       frame_done
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_STEPS - 1);

    dm_state_e  state;
    logic [7:0] dwell;
    logic [3:0] blank_cnt;
    logic       own_req;
    logic       other_req;
    logic [1:0] grant_swap;
    logic [7:0] mux_red;
    logic [7:0] mux_green;

    assign own_req    = |(req & grant);
    assign other_req  = |(req & ~grant);
    assign grant_swap = {grant[0], grant[1]};
    assign mux_red    = grant[1] ? src1_red   : src0_red;
    assign mux_green  = grant[1] ? src1_green : src0_green;

    dm_row_scanner u_scan (
        .clk       (clk),
        .rst       (rst),
        .tick      (scan_tick && state != IDLE),
        .clear     (!en || state == IDLE),
        .hold      (state == BLANK),
        .row_idx   (row_idx),
        .cow       (cow),
        .frame_done(frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state       <= IDLE;
            grant       <= 2'b00;
            dwell       <= 8'd0;
            blank_cnt   <= 4'd0;
            color_red   <= COL_OFF;
            color_green <= COL_OFF;
        end else begin
            unique case (state)
                IDLE: begin
                    color_red   <= COL_OFF;
                    color_green <= COL_OFF;
                    dwell       <= 8'd0;
                    blank_cnt   <= 4'd0;
                    if (|req) begin
                        grant <= req[0] ? 2'b01 : 2'b10;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_tick) begin
                        color_red   <= mux_red;
                        color_green <= mux_green;
                        // Ownership is only reconsidered on the row-7 tick.
                        if (row_idx == 3'd7) begin
                            if (other_req &&
                                (dwell >= DWELL_LAST || !own_req)) begin
                                grant     <= grant_swap;
                                dwell     <= 8'd0;
                                blank_cnt <= 4'd0;
                                state     <= BLANK;
                            end else if (!own_req) begin
                                grant <= 2'b00;
                                state <= IDLE;
                            end else if (dwell != 8'hFF) begin
                                dwell <= dwell + 8'd1;
                            end
                        end
                    end
                end
                BLANK: begin
                    if (scan_tick) begin
                        color_red   <= COL_OFF;
                        color_green <= COL_OFF;
                        if (blank_cnt == BLANK_LAST) begin
                            blank_cnt <= 4'd0;
                            // New owner gave up during the gap: fall back
                            // to the other source (already blanked) or idle.
                            if (own_req) begin
                                state <= SCAN;
                            end else if (other_req) begin
                                grant <= grant_swap;
                                state <= SCAN;
                            end else begin
                                grant <= 2'b00;
                                state <= IDLE;
                            end
                        end else begin
                            blank_cnt <= blank_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_scan_arbiter.md
Name: dm_scan_arbiter

Overview:
- Shares the 8x8 red/green dot-matrix display between two pattern sources (e.g. airplane game screen and countdown animation).
- Sequences the row scan and grants the display to one source at a time, at frame boundaries only.
- Enforces a minimum dwell per owner and blanks the matrix for a programmable number of scan steps on every owner change, to prevent ghosting.
- Sits between the pattern generators and the matrix pins (color_red, color_green, cow).

Parameters:
- DWELL_FRAMES, 64: minimum full frames an owner keeps the grant while the other source is requesting; range 1..255.
- BLANK_STEPS, 2: scan steps output blank after an owner change; range 1..15.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- scan_tick  input  1  one-cycle pulse per row step (1 kHz rate).
- en  input  1  display enable (power switch); 0 blanks the display and releases the grant.
- req  input  2  per-source display request; bit0 = source 0, bit1 = source 1.
- grant  output  2  one-hot current owner; 2'b00 when none.
- row_idx  output  3  row currently requested from the sources.
- src0_red, src0_green  input  8  source 0 row data for row_idx (combinational reply).
- src1_red, src1_green  input  8  source 1 row data for row_idx.
- color_red, color_green  output  8  registered column data to the matrix.
- cow  output  8  registered active-low one-hot row select.
- frame_done  output  1  one-cycle pulse after row 7 of a frame is driven.

Behaviour:
- Reset values:
  - cow=8'hFF, color_red=8'h00, color_green=8'h00
  - grant=2'b00, row_idx=0, frame_done=0
  - state IDLE; dwell and blank counters 0.
- States: IDLE, SCAN, BLANK.
- IDLE:
  - Outputs blank (cow=FF, colors=00).
  - If en and |req: next cycle grant = source 0 if req[0], else source 1 (fixed priority when idle). row_idx=0, dwell counter=0, state -> SCAN.
  - A scan_tick is not required to leave IDLE.
- SCAN, on scan_tick:
  - cow <= ~(8'b1 << row_idx).
  - color_red/green <= granted source data.
  - row_idx <= row_idx+1, wrapping 7 -> 0.
  - No output change between ticks.
  - The tick that drives row 7 raises frame_done for the next cycle only, and dwell counter increments, saturating at 255.
- Frame-boundary decision, in the same cycle as the row-7 tick, applied next cycle:
  - Other source requesting AND (dwell >= DWELL_FRAMES-1 OR owner req low): grant flips, dwell=0, blank counter=0, state -> BLANK.
  - Owner req low and other not requesting: grant=00, state -> IDLE.
  - Otherwise: keep owner and continue SCAN.
- Owner dropping req mid-frame: owner keeps the grant and its data is still muxed until the boundary. No mid-frame switch ever.
- BLANK:
  - Each scan_tick drives cow=FF and colors=00; blank counter increments and row_idx holds at 0.
  - After BLANK_STEPS ticks -> SCAN with the new owner. The first driven row is 0.
- If the new owner drops req during BLANK: at BLANK end go to IDLE, or back to the other source if it is requesting.
- en=0 in any state: next cycle state=IDLE, grant=00, outputs blank, row_idx=0, counters cleared. This overrides everything except rst.
- Simultaneous events:
  - rst beats en beats scan_tick.
  - A scan_tick arriving in the IDLE->SCAN transition cycle is ignored.
- Widths: dwell counter 8 bits, blank counter 4 bits. grant is always one-hot or zero.

Decomposition:
- Package dm_pkg holds:
  - state enum (IDLE/SCAN/BLANK)
  - ROW_ALL_OFF=8'hFF, COL_OFF=8'h00
  - function row_onehot_n(idx) returning the active-low row select.
- One sub-module, dm_row_scanner: row_idx counter, wrap, frame_done pulse, cow generation. Inputs: tick, clear, hold.
- Arbitration FSM, dwell/blank counters and output mux live in the top.

Test Plan:
- Reset/idle: rst 1 cycle, en=1, req=00, 20 ticks -> cow=FF, colors=00, grant=00 throughout.
- Single owner: req=01, src0_red=8'h18 all rows, 8 ticks -> grant=01; cow sequence FE,FD,FB,F7,EF,DF,BF,7F; color_red=18 each step; frame_done pulses once after 7F.
- Dwell and switch (DWELL_FRAMES=2, BLANK_STEPS=2): req=11 from idle.
  - grant=01 for exactly 2 frames (16 ticks).
  - Then 2 ticks with cow=FF and colors=00.
  - Then grant=10 and the next cow=FE carries src1 data.
- Mid-frame drop: owner=0, deassert req[0] at row 3 with req[1]=1 -> rows 4..7 still show src0 data; switch and blank start only after row 7.
- Owner release, no contender: req 01 -> 00 mid-frame -> frame completes, then grant=00, cow=FF.
- en drop and reset mid-operation:
  - en=0 during row 5 -> next cycle cow=FF, grant=00, row_idx=0.
  - Re-enable -> first driven row is FE.
  - rst asserted in BLANK -> all outputs at reset values the next cycle.
